// File: rtl/ysyx_24100006_sram.sv
// Single-port word SRAM behind a valid/ready request/response handshake.
// One request in flight at a time; the response appears a fixed LATENCY edges after accept.
module ysyx_24100006_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] index;
    logic        in_range;
    logic [IDX_W-1:0] mem_idx;
    logic        mem_we;

    assign index    = (addr_q - ADDR_BASE) >> 2;
    assign in_range = (addr_q >= ADDR_BASE) && (index < DEPTH_W);
    assign mem_idx  = index[IDX_W-1:0];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The access happens on the edge that leaves WAIT, so storage and
                // response data are both decided from the latched request only.
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    rsp_err_d = !in_range;
                    if (write_q) begin
                        rsp_rdata_d = 32'h0;
                        mem_we      = in_range;
                    end else begin
                        rsp_rdata_d = in_range ? mem[mem_idx] : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately not reset; an aborted write never reaches mem_we
    // because reset forces the state register back to IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_sram.sv
// Directed self-checking bench for ysyx_24100006_sram (default parameters, LATENCY = 2).
module tb_ysyx_24100006_sram;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    ysyx_24100006_sram dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic clearReq();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wmask = 4'h0;
    endtask

    // Issue one request with rsp_ready held high; checks latency, payload and the handshake.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic [31:0] exp_rdata,
                                 input logic exp_err, input string tag);
        int edges;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        clearReq();
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!rsp_valid && edges < 20);
        checkOutput({tag, "_lat"}, 32'(edges), 32'd2);
        checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        checkOutput({tag, "_vld_clr"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rdy_set"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        clearReq();
        rsp_ready = 1'b1;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr_full");
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd_full");
        applyStimulus(1'b1, 32'h8000_0012, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, "wr_lane1");
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_ABEF, 1'b0, "rd_lane1");
        applyStimulus(1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor_hi");
        applyStimulus(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor_lo");
        applyStimulus(1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 32'h0, 1'b0, "wr_word0");
        applyStimulus(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_oor");
        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0123_4567, 1'b0, "rd_word0");
        applyStimulus(1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "wr_last");
        applyStimulus(1'b0, 32'h8000_0FFF, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "rd_last");
        applyStimulus(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "wr_nomask");
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, "rd_nomask");

        // Backpressure: response must hold while req_* wiggles and nothing new is accepted.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8000_0FFC;
        @(posedge clk); #1;
        clearReq();
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!rsp_valid && edges < 20);
        checkOutput("stall_lat", 32'(edges), 32'd2);
        for (int i = 0; i < 5; i++) begin
            req_valid = ~i[0];
            req_write = 1'b1;
            req_addr  = 32'h8000_0FFC;
            req_wdata = 32'h0BAD_0000 + 32'(i);
            req_wmask = 4'hF;
            @(posedge clk); #1;
            checkOutput("stall_vld", 32'(rsp_valid), 32'h1);
            checkOutput("stall_rdata", rsp_rdata, 32'hCAFE_F00D);
            checkOutput("stall_rdy", 32'(req_ready), 32'h0);
        end
        clearReq();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_hs_rdy", 32'(req_ready), 32'h1);
        checkOutput("stall_hs_vld", 32'(rsp_valid), 32'h0);
        applyStimulus(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "rd_after_stall");

        // Reset in the middle of WAIT must abort the write before its access edge.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h8000_0010;
        req_wdata = 32'h1111_1111;
        req_wmask = 4'hF;
        @(posedge clk); #1;
        clearReq();
        checkOutput("wait_rdy", 32'(req_ready), 32'h0);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_rdy", 32'(req_ready), 32'h1);
        checkOutput("abort_vld", 32'(rsp_valid), 32'h0);
        checkOutput("abort_rdata", rsp_rdata, 32'h0);
        checkOutput("abort_err", 32'(rsp_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_hold_vld", 32'(rsp_valid), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, "rd_after_abort");

        // Reset while a read response is pending clears the held payload immediately.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        @(posedge clk); #1;
        clearReq();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resp_pend_rdata", rsp_rdata, 32'h0123_4567);
        #2 reset = 1'b0;
        #1;
        checkOutput("resp_rst_vld", 32'(rsp_valid), 32'h0);
        checkOutput("resp_rst_rdata", rsp_rdata, 32'h0);
        checkOutput("resp_rst_rdy", 32'(req_ready), 32'h1);
        @(negedge clk) reset = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
